// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer
//  Description : Microprogram sequencer with a writable microstore, a writable
//                opcode dispatch table and a bounded call/return micro-stack.
//                One registered microword of control signals per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module micro_sequencer #(
    parameter int OPCODE_W    = 5,
    parameter int FLAG_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int SIG_W       = 24,
    parameter int STACK_DEPTH = 4,
    parameter int COND_W      = $clog2(FLAG_W),
    parameter int WORD_W      = ADDR_W + COND_W + 1 + 3 + SIG_W
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              stall,
    input  logic [OPCODE_W-1:0]                               opcode,
    input  logic [FLAG_W-1:0]                                 flags,
    input  logic                                              ld_en,
    input  logic                                              ld_sel,
    input  logic [((ADDR_W > OPCODE_W) ? ADDR_W : OPCODE_W)-1:0] ld_addr,
    input  logic [WORD_W-1:0]                                 ld_data,
    output logic [SIG_W-1:0]                                  signals,
    output logic [ADDR_W-1:0]                                 upc,
    output logic                                              halted,
    output logic                                              err
);

    // Sequencing operations carried in every microword
    typedef enum logic [2:0] {
        OP_JUMP     = 3'd0,
        OP_INC      = 3'd1,
        OP_DISPATCH = 3'd2,
        OP_BRANCH   = 3'd3,
        OP_CALL     = 3'd4,
        OP_RET      = 3'd5,
        OP_HALT     = 3'd6,
        OP_ILLEGAL  = 3'd7
    } seq_op_e;

    // Microword field positions, LSB upwards: signals, seq_op, cond_inv, cond_sel, next_addr
    localparam int OP_LO   = SIG_W;
    localparam int INV_BIT = SIG_W + 3;
    localparam int CS_LO   = SIG_W + 4;
    localparam int NA_LO   = SIG_W + 4 + COND_W;

    // Stack pointer counts 0..STACK_DEPTH; entry index is its low bits
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int STK_N = 2 ** IDX_W;

    // Storage arrays (no reset: contents are undefined until loaded)
    logic [WORD_W-1:0] store_q    [2**ADDR_W];
    logic [ADDR_W-1:0] dispatch_q [2**OPCODE_W];

    // Sequencer state
    logic [WORD_W-1:0] current_q, current_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [ADDR_W-1:0] stack_q [STK_N];
    logic [ADDR_W-1:0] stack_d [STK_N];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;

    // Decode of the current microword
    seq_op_e           w_op;
    logic [ADDR_W-1:0] w_next_addr;
    logic [COND_W-1:0] w_cond_sel;
    logic              w_cond;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [SP_W-1:0]   w_sp_dec;
    logic              w_stack_full;
    logic              w_stack_empty;

    assign w_op          = seq_op_e'(current_q[OP_LO +: 3]);
    assign w_next_addr   = current_q[NA_LO +: ADDR_W];
    assign w_cond_sel    = current_q[CS_LO +: COND_W];
    assign w_cond        = flags[w_cond_sel] ^ current_q[INV_BIT];
    assign w_upc_inc     = upc_q + ADDR_W'(1);
    assign w_sp_dec      = sp_q - SP_W'(1);
    assign w_stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign w_stack_empty = (sp_q == '0);

    // Target address and stack/error side effects of the current microword
    logic [ADDR_W-1:0] w_target;
    logic              w_advance;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;

    // Target selection from seq_op
    always_comb begin
        w_target  = w_upc_inc;
        w_advance = 1'b1;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        case (w_op)
            OP_JUMP:     w_target = w_next_addr;
            OP_INC:      w_target = w_upc_inc;
            OP_DISPATCH: w_target = dispatch_q[opcode];
            OP_BRANCH:   w_target = w_cond ? w_next_addr : w_upc_inc;
            OP_CALL: begin
                w_target = w_next_addr;
                if (w_stack_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            OP_RET: begin
                if (w_stack_empty) begin
                    w_target  = '0;
                    w_err_set = 1'b1;
                end else begin
                    w_target = stack_q[w_sp_dec[IDX_W-1:0]];
                    w_pop    = 1'b1;
                end
            end
            OP_HALT:     w_advance = 1'b0;
            default: begin
                w_target  = '0;
                w_err_set = 1'b1;
            end
        endcase
    end

    // Next-state: advance only when neither stalled nor halted
    always_comb begin
        current_d = current_q;
        upc_d     = upc_q;
        stack_d   = stack_q;
        sp_d      = sp_q;
        err_d     = err_q;
        if (!stall && w_advance) begin
            current_d = store_q[w_target];
            upc_d     = w_target;
            err_d     = err_q | w_err_set;
            if (w_push) begin
                stack_d[sp_q[IDX_W-1:0]] = w_upc_inc;
                sp_d                     = sp_q + SP_W'(1);
            end else if (w_pop) begin
                sp_d = w_sp_dec;
            end
        end
    end

    // Sequencer state register; reset word is JUMP 0 with all signals low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_q <= '0;
            upc_q     <= '0;
            sp_q      <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < STK_N; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            current_q <= current_d;
            upc_q     <= upc_d;
            sp_q      <= sp_d;
            err_q     <= err_d;
            stack_q   <= stack_d;
        end
    end

    // Table writes: independent of stall/reset; same-cycle fetch sees old data
    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (!ld_sel) begin
                store_q[ld_addr[ADDR_W-1:0]] <= ld_data;
            end else begin
                dispatch_q[ld_addr[OPCODE_W-1:0]] <= ld_data[ADDR_W-1:0];
            end
        end
    end

    assign signals = current_q[SIG_W-1:0];
    assign upc     = upc_q;
    assign halted  = (w_op == OP_HALT);
    assign err     = err_q;

endmodule
`default_nettype wire
